icache_miss_handler: RTL and testbench

- Stage that sits directly downstream of the tag checker (stage 2); consumes its miss reports.
- On a miss it picks a victim way from the status-array bits and fetches the 16-word line from memory in 4 beats.
- It writes each beat into the data arrays, then updates the tag array and the status array.
- It then replays the missed address to stage 1 through the restart intercept port. While busy it drives the miss-state flag to stage 1.

---
 rtl/icache_miss_handler.sv | 164 ++++++++++++++++
 tb/tb_icache_miss_handler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_miss_handler.sv
// Instruction-cache miss handler: picks a victim way, fetches the missed line in beats,
// fills data/tag/status arrays, then replays the missed fetch address to stage 1.
module icache_miss_handler #(
  parameter int ADDR_WIDTH     = 16,
  parameter int WORD_WIDTH     = 20,
  parameter int NUM_WAYS       = 4,
  parameter int BEAT_WORDS     = 4,
  parameter int TAG_BITS_WIDTH = 8,
  localparam int OFF_W  = 4,
  localparam int SET_W  = ADDR_WIDTH - TAG_BITS_WIDTH - OFF_W,
  localparam int BEAT_W = WORD_WIDTH * BEAT_WORDS,
  localparam int BEATS  = (2 ** OFF_W) / BEAT_WORDS,
  localparam int CNT_W  = $clog2(BEATS)
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           i_halt,
  input  logic                           i_miss_valid,
  input  logic [TAG_BITS_WIDTH-1:0]      i_miss_tag,
  input  logic [SET_W-1:0]               i_miss_set,
  input  logic [OFF_W-1:0]               i_miss_offset,
  input  logic [2*NUM_WAYS-1:0]          i_miss_sa_data,
  output logic                           o_miss_ready,
  output logic                           o_miss_state,
  output logic [ADDR_WIDTH-1:0]          o_mem_addr,
  output logic                           o_mem_req_valid,
  input  logic [BEAT_W-1:0]              i_mem_data,
  input  logic                           i_mem_data_valid,
  output logic [SET_W+CNT_W-1:0]         o_da_w_addr,
  output logic [BEAT_W-1:0]              o_da_w_data,
  output logic [NUM_WAYS-1:0]            o_da_w_mask,
  output logic                           o_da_w_valid,
  output logic [SET_W-1:0]               o_ta_w_addr,
  output logic [TAG_BITS_WIDTH*NUM_WAYS-1:0] o_ta_w_data,
  output logic [NUM_WAYS-1:0]            o_ta_w_mask,
  output logic                           o_ta_w_valid,
  output logic [SET_W-1:0]               o_sa_w_addr,
  output logic [2*NUM_WAYS-1:0]          o_sa_w_data,
  output logic [2*NUM_WAYS-1:0]          o_sa_w_mask,
  output logic                           o_sa_w_valid,
  output logic [ADDR_WIDTH-1:0]          o_r_addr,
  output logic                           o_r_valid
);

  typedef enum logic [2:0] {IDLE, REQ, FILL, UPDATE, RESTART} state_t;

  state_t                    state;
  logic [TAG_BITS_WIDTH-1:0] tag_q;
  logic [SET_W-1:0]          set_q;
  logic [OFF_W-1:0]          off_q;
  logic [NUM_WAYS-1:0]       victim_q;
  logic [NUM_WAYS-1:0]       victim;
  logic [CNT_W-1:0]          cnt;
  logic                      mem_req_q;
  logic                      upd_q;
  logic                      r_valid_q;
  logic                      found_inv;
  logic                      found_unused;

  // Status lane per way is {valid, use}: first invalid way, else first unused way, else way 0.
  always_comb begin
    victim       = '0;
    found_inv    = 1'b0;
    found_unused = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!found_inv && !i_miss_sa_data[2*w+1]) begin
        victim    = '0;
        victim[w] = 1'b1;
        found_inv = 1'b1;
      end
    end
    if (!found_inv) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        if (!found_unused && !i_miss_sa_data[2*w]) begin
          victim       = '0;
          victim[w]    = 1'b1;
          found_unused = 1'b1;
        end
      end
      if (!found_unused) victim[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= IDLE;
      tag_q        <= '0;
      set_q        <= '0;
      off_q        <= '0;
      victim_q     <= '0;
      cnt          <= '0;
      mem_req_q    <= 1'b0;
      upd_q        <= 1'b0;
      r_valid_q    <= 1'b0;
      o_da_w_valid <= 1'b0;
      o_da_w_addr  <= '0;
      o_da_w_data  <= '0;
    end else begin
      mem_req_q    <= 1'b0;
      upd_q        <= 1'b0;
      o_da_w_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_miss_valid && !i_halt) begin
            tag_q     <= i_miss_tag;
            set_q     <= i_miss_set;
            off_q     <= i_miss_offset;
            victim_q  <= victim;
            mem_req_q <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: state <= FILL;
        // Memory cannot be back-pressured, so beats are accepted regardless of i_halt.
        FILL: begin
          if (i_mem_data_valid) begin
            o_da_w_valid <= 1'b1;
            o_da_w_data  <= i_mem_data;
            o_da_w_addr  <= {set_q, cnt};
            cnt          <= cnt + 1'b1;
            if (cnt == CNT_W'(BEATS - 1)) begin
              upd_q <= 1'b1;
              state <= UPDATE;
            end
          end
        end
        UPDATE: begin
          r_valid_q <= 1'b1;
          state     <= RESTART;
        end
        RESTART: begin
          if (!i_halt) begin
            r_valid_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_sa_w_mask = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      o_sa_w_mask[2*w+:2] = {2{victim_q[w]}};
    end
  end

  assign o_miss_ready    = (state == IDLE) && !i_halt;
  assign o_miss_state    = (state != IDLE);
  assign o_mem_addr      = {tag_q, set_q, {OFF_W{1'b0}}};
  assign o_mem_req_valid = mem_req_q;
  assign o_da_w_mask     = victim_q;
  assign o_ta_w_addr     = set_q;
  assign o_ta_w_data     = {NUM_WAYS{tag_q}};
  assign o_ta_w_mask     = victim_q;
  assign o_ta_w_valid    = upd_q;
  assign o_sa_w_addr     = set_q;
  assign o_sa_w_data     = {(2*NUM_WAYS){upd_q}};
  assign o_sa_w_valid    = upd_q;
  assign o_r_addr        = {tag_q, set_q, off_q};
  assign o_r_valid       = r_valid_q;

endmodule

// File: tb/tb_icache_miss_handler.sv
// Directed bench for icache_miss_handler: line fills, victim choice, gaps, halts, reset.
module tb_icache_miss_handler;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        i_halt;
  logic        i_miss_valid;
  logic [7:0]  i_miss_tag;
  logic [3:0]  i_miss_set;
  logic [3:0]  i_miss_offset;
  logic [7:0]  i_miss_sa_data;
  logic        o_miss_ready;
  logic        o_miss_state;
  logic [15:0] o_mem_addr;
  logic        o_mem_req_valid;
  logic [79:0] i_mem_data;
  logic        i_mem_data_valid;
  logic [5:0]  o_da_w_addr;
  logic [79:0] o_da_w_data;
  logic [3:0]  o_da_w_mask;
  logic        o_da_w_valid;
  logic [3:0]  o_ta_w_addr;
  logic [31:0] o_ta_w_data;
  logic [3:0]  o_ta_w_mask;
  logic        o_ta_w_valid;
  logic [3:0]  o_sa_w_addr;
  logic [7:0]  o_sa_w_data;
  logic [7:0]  o_sa_w_mask;
  logic        o_sa_w_valid;
  logic [15:0] o_r_addr;
  logic        o_r_valid;

  int vectors = 0;
  int miscompares = 0;

  icache_miss_handler #(
    .ADDR_WIDTH(16), .WORD_WIDTH(20), .NUM_WAYS(4), .BEAT_WORDS(4), .TAG_BITS_WIDTH(8)
  ) dut (
    .clk(clk), .arst_n(arst_n), .i_halt(i_halt),
    .i_miss_valid(i_miss_valid), .i_miss_tag(i_miss_tag), .i_miss_set(i_miss_set),
    .i_miss_offset(i_miss_offset), .i_miss_sa_data(i_miss_sa_data),
    .o_miss_ready(o_miss_ready), .o_miss_state(o_miss_state),
    .o_mem_addr(o_mem_addr), .o_mem_req_valid(o_mem_req_valid),
    .i_mem_data(i_mem_data), .i_mem_data_valid(i_mem_data_valid),
    .o_da_w_addr(o_da_w_addr), .o_da_w_data(o_da_w_data), .o_da_w_mask(o_da_w_mask),
    .o_da_w_valid(o_da_w_valid),
    .o_ta_w_addr(o_ta_w_addr), .o_ta_w_data(o_ta_w_data), .o_ta_w_mask(o_ta_w_mask),
    .o_ta_w_valid(o_ta_w_valid),
    .o_sa_w_addr(o_sa_w_addr), .o_sa_w_data(o_sa_w_data), .o_sa_w_mask(o_sa_w_mask),
    .o_sa_w_valid(o_sa_w_valid),
    .o_r_addr(o_r_addr), .o_r_valid(o_r_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] beat_data(input int b);
    logic [79:0] r;
    for (int k = 0; k < 4; k++) r[20*k+:20] = 20'hB0000 | 20'(b * 16 + k);
    return r;
  endfunction

  // One full miss; pat bit c = beat valid in the c-th FILL cycle.
  task automatic do_miss(input logic [7:0] tag, input logic [3:0] set, input logic [3:0] off,
                         input logic [7:0] sa, input logic [3:0] way, input logic [15:0] pat,
                         input logic halt_fill, input int rhalt);
    logic [7:0] smask;
    int         beats;
    int         c;
    logic       prev_v;
    for (int i = 0; i < 4; i++) smask[2*i+:2] = {2{way[i]}};
    i_miss_valid = 1'b1; i_miss_tag = tag; i_miss_set = set; i_miss_offset = off;
    i_miss_sa_data = sa;
    #1;
    chk("idle_ready", o_miss_ready, 1'b1);
    chk("idle_req", o_mem_req_valid, 1'b0);
    tick;
    // REQ cycle; a spurious beat here must be ignored
    i_miss_valid = 1'b0; i_mem_data_valid = 1'b1; i_mem_data = '1;
    #1;
    chk("req_valid", o_mem_req_valid, 1'b1);
    chk("req_addr", o_mem_addr, {tag, set, 4'h0});
    chk("req_busy", {o_miss_state, o_miss_ready}, 2'b10);
    tick;
    beats = 0; c = 0; prev_v = 1'b0;
    while (beats < 4 && c < 16) begin
      i_halt = halt_fill;
      i_mem_data_valid = pat[c];
      i_mem_data = beat_data(beats);
      i_miss_valid = 1'b1; i_miss_tag = 8'hFF; i_miss_set = ~set; i_miss_offset = ~off;
      #1;
      chk("fill_da_valid", o_da_w_valid, prev_v);
      if (prev_v) begin
        chk("fill_da_addr", o_da_w_addr, {set, 2'(beats - 1)});
        chk("fill_da_data", o_da_w_data, beat_data(beats - 1));
        chk("fill_da_mask", o_da_w_mask, way);
      end
      chk("fill_no_ta", {o_ta_w_valid, o_sa_w_valid, o_mem_req_valid, o_r_valid}, 4'b0);
      chk("fill_busy", {o_miss_state, o_miss_ready}, 2'b10);
      prev_v = pat[c];
      if (pat[c]) beats++;
      c++;
      tick;
    end
    chk("fill_beats", 80'(beats), 80'd4);
    i_mem_data_valid = 1'b0; i_halt = 1'b0; i_miss_valid = 1'b0;
    #1;
    chk("upd_da_valid", o_da_w_valid, 1'b1);
    chk("upd_da_addr", o_da_w_addr, {set, 2'd3});
    chk("upd_da_data", o_da_w_data, beat_data(3));
    chk("upd_ta", {o_ta_w_valid, o_ta_w_addr, o_ta_w_mask}, {1'b1, set, way});
    chk("upd_ta_data", o_ta_w_data, {4{tag}});
    chk("upd_sa", {o_sa_w_valid, o_sa_w_addr, o_sa_w_data}, {1'b1, set, 8'hFF});
    chk("upd_sa_mask", o_sa_w_mask, smask);
    chk("upd_no_restart", o_r_valid, 1'b0);
    tick;
    for (int h = 0; h <= rhalt; h++) begin
      i_halt = (h < rhalt);
      #1;
      chk("rst_valid", o_r_valid, 1'b1);
      chk("rst_addr", o_r_addr, {tag, set, off});
      chk("rst_quiet", {o_da_w_valid, o_ta_w_valid, o_sa_w_valid, o_miss_ready}, 4'b0);
      chk("rst_busy", o_miss_state, 1'b1);
      tick;
    end
    i_halt = 1'b0;
    #1;
    chk("done_idle", {o_r_valid, o_miss_state, o_miss_ready, o_mem_req_valid}, 4'b0010);
  endtask

  initial begin
    arst_n = 1'b0; i_halt = 1'b0; i_miss_valid = 1'b0; i_miss_tag = '0; i_miss_set = '0;
    i_miss_offset = '0; i_miss_sa_data = '0; i_mem_data = '0; i_mem_data_valid = 1'b0;
    #12;
    chk("reset_ctl", {o_miss_state, o_mem_req_valid, o_mem_addr, o_r_valid, o_r_addr}, '0);
    chk("reset_wr", {o_da_w_valid, o_ta_w_valid, o_sa_w_valid, o_sa_w_data}, '0);
    #10 arst_n = 1'b1;
    tick;
    chk("reset_ready", o_miss_ready, 1'b1);

    // Halted in IDLE: miss must not be accepted
    i_halt = 1'b1; i_miss_valid = 1'b1; i_miss_tag = 8'h11; i_miss_set = 4'h2;
    #1;
    chk("halt_ready", o_miss_ready, 1'b0);
    tick;
    chk("halt_no_accept", {o_miss_state, o_mem_req_valid}, 2'b00);
    i_halt = 1'b0; i_miss_valid = 1'b0;

    // Spurious beat in IDLE
    i_mem_data_valid = 1'b1; i_mem_data = '1;
    tick;
    chk("idle_spurious", {o_da_w_valid, o_miss_state}, 2'b00);
    i_mem_data_valid = 1'b0;

    do_miss(8'hA5, 4'h3, 4'hC, 8'h00,        4'b0001, 16'h000F, 1'b0, 0);
    do_miss(8'h3C, 4'h7, 4'h1, 8'b11011111,  4'b0100, 16'h000F, 1'b1, 3);
    do_miss(8'h5A, 4'hE, 4'h9, 8'hFF,        4'b0001, 16'h0219, 1'b0, 0);
    do_miss(8'h07, 4'h0, 4'hF, 8'b11001111,  4'b0100, 16'h000F, 1'b0, 1);
    do_miss(8'hC3, 4'h9, 4'h4, 8'hFB,        4'b0010, 16'h0055, 1'b0, 0);
    do_miss(8'h81, 4'h5, 4'h2, 8'b00111111,  4'b1000, 16'h000F, 1'b0, 0);

    // Reset after two beats
    i_miss_valid = 1'b1; i_miss_tag = 8'h12; i_miss_set = 4'h5; i_miss_offset = 4'h6;
    i_miss_sa_data = 8'h00;
    tick;
    i_miss_valid = 1'b0;
    tick;
    i_mem_data_valid = 1'b1; i_mem_data = beat_data(0);
    tick;
    i_mem_data = beat_data(1);
    tick;
    i_mem_data_valid = 1'b0;
    #1;
    chk("pre_reset_da", o_da_w_valid, 1'b1);
    arst_n = 1'b0;
    #1;
    chk("mid_reset_ctl", {o_miss_state, o_mem_req_valid, o_mem_addr, o_r_valid, o_r_addr}, '0);
    chk("mid_reset_da", {o_da_w_valid, o_da_w_addr, o_da_w_mask}, '0);
    chk("mid_reset_da_data", o_da_w_data, '0);
    chk("mid_reset_ta", {o_ta_w_valid, o_ta_w_addr, o_ta_w_data, o_ta_w_mask}, '0);
    chk("mid_reset_sa", {o_sa_w_valid, o_sa_w_addr, o_sa_w_data, o_sa_w_mask}, '0);
    tick;
    arst_n = 1'b1;
    #1;
    chk("post_reset_ready", o_miss_ready, 1'b1);
    i_mem_data_valid = 1'b1; i_mem_data = beat_data(2);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("post_reset_quiet", {o_da_w_valid, o_ta_w_valid, o_sa_w_valid, o_miss_state}, 4'b0);
    end
    i_mem_data_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
